// File: rtl/cpu_bus_trace_monitor.sv
// cpu_bus_trace_monitor
//   Observes a 65xx CPU bus. Keeps a free-running cycle counter, pushes a
//   periodic sample every 2^INTERVAL_LOG2 cycles and an entry on every
//   address watchpoint hit into a show-ahead trace FIFO. A watchpoint hit can
//   optionally stall the CPU (ready=0) until a resume pulse is seen.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   address, data_i,      observed CPU bus (read data, write data, strobe)
//   data_o, write
//   wp_addr, wp_en        watchpoint slots (slot i at [i*ADDR_W +: ADDR_W])
//   halt_on_wp, resume    stall control
//   ready                 CPU ready input
//   cycle_count           current cycle number
//   trace_valid/ready/data trace stream, {periodic, wp_hit, write, data, address, stamp}
//   fifo_level            FIFO occupancy
//   drop_count            saturating count of entries lost to a full FIFO
module cpu_bus_trace_monitor #(
   parameter int unsigned ADDR_W        = 16,
   parameter int unsigned DATA_W        = 8,
   parameter int unsigned CNT_W         = 64,
   parameter int unsigned INTERVAL_LOG2 = 16,
   parameter int unsigned DEPTH         = 16,
   parameter int unsigned NUM_WP        = 2
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [ADDR_W-1:0]                 address,
   input  logic [DATA_W-1:0]                 data_i,
   input  logic [DATA_W-1:0]                 data_o,
   input  logic                              write,
   input  logic [NUM_WP*ADDR_W-1:0]          wp_addr,
   input  logic [NUM_WP-1:0]                 wp_en,
   input  logic                              halt_on_wp,
   input  logic                              resume,
   output logic                              ready,
   output logic [CNT_W-1:0]                  cycle_count,
   output logic                              trace_valid,
   input  logic                              trace_ready,
   output logic [CNT_W+ADDR_W+DATA_W+2:0]    trace_data,
   output logic [$clog2(DEPTH):0]            fifo_level,
   output logic [15:0]                       drop_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned EW = CNT_W + ADDR_W + DATA_W + 3;
   // Low INTERVAL_LOG2 bits of the counter; all-zero mask means every cycle ticks.
   localparam logic [CNT_W-1:0] TICK_MASK = (CNT_W'(1) << INTERVAL_LOG2) - CNT_W'(1);

   typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_STEP} state_t;

   state_t              state;
   logic [EW-1:0]       mem [DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [LW-1:0]       count;

   logic                wp_match;
   logic                hit;
   logic                tick;
   logic                capture;
   logic                pop;
   logic                full;
   logic                push_ok;
   logic [LW-1:0]       count_nxt;
   logic [DATA_W-1:0]   bus_data;
   logic [EW-1:0]       entry;

   // Watchpoint compare, capture decision and FIFO next occupancy.
   always_comb begin
      wp_match = 1'b0;
      for (int unsigned i = 0; i < NUM_WP; i++) begin
         if (wp_en[i] && (address == wp_addr[i*ADDR_W +: ADDR_W]))
            wp_match = 1'b1;
      end
      // ready=1 excludes HALT; STEP is excluded so a frozen address cannot re-trigger.
      hit      = wp_match && ready && (state != ST_STEP);
      tick     = (cycle_count & TICK_MASK) == '0;
      capture  = tick || hit;
      pop      = trace_valid && trace_ready;
      full     = (count == LW'(DEPTH));
      push_ok  = capture && (!full || pop);
      bus_data = write ? data_o : data_i;
      entry    = {tick, hit, write, bus_data, address, cycle_count};
      count_nxt = count;
      if (push_ok && !pop)
         count_nxt = count + LW'(1);
      else if (!push_ok && pop)
         count_nxt = count - LW'(1);
   end

   // Cycle counter, FIFO storage/pointers and drop counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle_count <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         trace_valid <= 1'b0;
         drop_count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else begin
         cycle_count <= cycle_count + CNT_W'(1);
         // When full with a pop, wr_ptr equals rd_ptr: the slot being vacated takes the new tail.
         if (push_ok) begin
            mem[wr_ptr] <= entry;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         count       <= count_nxt;
         trace_valid <= (count_nxt != '0);
         if (capture && full && !pop && (drop_count != 16'hFFFF))
            drop_count <= drop_count + 16'd1;
      end
   end

   // Stall FSM: ready is registered alongside the state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_RUN;
         ready <= 1'b1;
      end else begin
         case (state)
            ST_RUN: begin
               if (hit && halt_on_wp) begin
                  state <= ST_HALT;
                  ready <= 1'b0;
               end
            end
            ST_HALT: begin
               if (resume) begin
                  state <= ST_STEP;
                  ready <= 1'b1;
               end
            end
            ST_STEP: begin
               state <= ST_RUN;
               ready <= 1'b1;
            end
            default: begin
               state <= ST_RUN;
               ready <= 1'b1;
            end
         endcase
      end
   end

   // Show-ahead head; storage is cleared on reset so this reads 0 when empty after reset.
   assign trace_data = mem[rd_ptr];
   assign fifo_level = count;

endmodule

// File: doc/cpu_bus_trace_monitor.md
Name: cpu_bus_trace_monitor

Overview:
Parametrised bus-observation block that sits beside a 65xx CPU core on its address, data and write lines. It keeps a free-running cycle counter and samples the bus periodically into a trace FIFO. It adds address watchpoints that log matching cycles and can optionally stall the CPU through its ready input until software or the bench issues a resume. The trace is drained through a valid/ready stream.

Parameters:
ADDR_W, 16, CPU address width.
DATA_W, 8, CPU data width.
CNT_W, 64, cycle counter and timestamp width.
INTERVAL_LOG2, 16, periodic sample every 2^INTERVAL_LOG2 cycles; 0 means every cycle.
DEPTH, 16, trace FIFO entries; power of two, at least 2.
NUM_WP, 2, number of address watchpoints; at least 1.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
address  in  ADDR_W  CPU address out.
data_i  in  DATA_W  data the CPU reads (memory to CPU).
data_o  in  DATA_W  data the CPU writes.
write  in  1  CPU write strobe.
wp_addr  in  NUM_WP*ADDR_W  watchpoint addresses; slot i occupies bits [i*ADDR_W +: ADDR_W].
wp_en  in  NUM_WP  per-watchpoint enable.
halt_on_wp  in  1  a watchpoint hit stalls the CPU.
resume  in  1  single-cycle pulse that leaves the HALT state.
ready  out  1  drives the CPU ready input.
cycle_count  out  CNT_W  current cycle number.
trace_valid  out  1  FIFO head valid.
trace_ready  in  1  consumer accepts the head entry.
trace_data  out  CNT_W+ADDR_W+DATA_W+3  packed as {periodic, wp_hit, write, data, address, stamp}, MSB first.
fifo_level  out  $clog2(DEPTH)+1  current occupancy.
drop_count  out  16  number of lost entries; saturates.

Behaviour:
- Reset values: cycle_count=0, FIFO empty, fifo_level=0, trace_valid=0, trace_data=0, drop_count=0, FSM=RUN, ready=1.
- Cycle counter: C is the value held during a cycle. At each edge it becomes C+1 and wraps modulo 2^CNT_W.
- Periodic tick: true in a cycle whose C has its low INTERVAL_LOG2 bits all zero. The first tick is at C=0 after reset.
- Watchpoint hit: true when some i has wp_en[i]=1, address equal to slot i, ready=1, and FSM is not STEP.
- Capture: if tick or hit, one entry is pushed at the edge ending cycle C.
  - stamp=C.
  - data=data_o when write=1, otherwise data_i.
  - Periodic and hit in the same cycle give one entry with both flags set.
- FIFO push/pop:
  - Pop occurs when trace_valid and trace_ready.
  - Head is show-ahead. trace_data must stay stable while trace_valid=1 and trace_ready=0.
  - Push into a full FIFO with no pop in the same cycle: entry is dropped and drop_count increments, saturating at 16'hFFFF.
  - Full FIFO with pop and push in the same cycle: the push is accepted and the level is unchanged.
  - Empty FIFO with push: the entry appears on trace_valid/trace_data the next cycle; no fall-through in the same cycle.
- FSM (states RUN, HALT, STEP):
  - RUN: ready=1. hit with halt_on_wp=1 moves to HALT; ready=0 from the next cycle. The hit entry is still logged.
  - HALT: ready=0 and no hits are evaluated. resume=1 moves to STEP.
  - STEP: ready=1 for exactly one cycle with hit detection suppressed, so the frozen address does not re-trigger. Then unconditionally RUN.
  - resume in RUN or STEP is ignored.
  - halt_on_wp dropping to 0 during HALT does not release; only resume does.
- Periodic sampling continues in every FSM state.
- Asserting reset in any state, including mid-HALT, restores all reset values immediately (asynchronous).

Test Plan:
1. INTERVAL_LOG2=2, DEPTH=4, trace_ready=1, no watchpoints -> entries with stamps 0,4,8,12 appear, periodic=1, wp_hit=0; fifo_level never exceeds 1.
2. Same parameters, trace_ready=0 for 6 ticks -> fifo_level=4, drop_count=2; draining returns stamps 0,4,8,12 in order, with trace_data stable while stalled.
3. INTERVAL_LOG2=3, wp_addr0=16'hFFFC, wp_en=01, halt_on_wp=1, address=FFFC in cycle 5 -> entry {periodic 0, wp_hit 1, stamp 5}; ready=0 from cycle 6. Address held for 10 cycles gives no further wp entries. resume pulse -> ready=1 for one cycle (STEP), then RUN.
4. Watchpoint on address 16'h0008 hit at C=8 with INTERVAL_LOG2=3 -> exactly one entry with periodic=1 and wp_hit=1.
5. FIFO full, trace_ready=1, and a tick in the same cycle -> level stays 4, drop_count unchanged, new entry appended at the tail.
6. Reset asserted during HALT with 3 entries queued -> ready=1, trace_valid=0, fifo_level=0, cycle_count=0 without waiting for a clock edge.
